mul_sequencer: RTL and testbench

MUL_SEQUENCER -- requirements
Module: mul_sequencer

---
 rtl/mul_seq_pkg.sv | 13 +
 rtl/mul_sequencer_fulladder.sv | 23 ++
 rtl/mul_sequencer.sv | 81 ++++++++
 tb/tb_mul_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Shared constants for the shift-add multiply sequencer: operand width,
// iteration counter sizing and FSM state encoding.
package mul_seq_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_ITER = 4'd15;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mul_sequencer_fulladder.sv
// Combinational W-bit ripple-carry adder with carry in/out; zero latency.
module FullAdder #(
  parameter int W = 16
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         CIN,
  output logic [W-1:0] S,
  output logic         COUT
);

  logic [W:0] c;

  assign c[0] = CIN;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign S[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign COUT = c[W];

endmodule

// File: rtl/mul_sequencer.sv
// 16x16 unsigned shift-add multiplier; DONE 17 cycles after START is taken.
// START is ignored (not queued) while BUSY; new START accepted right after DONE.
module mul_sequencer #(
  parameter int WIDTH = mul_seq_pkg::WIDTH
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               START,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               BUSY,
  output logic               DONE,
  output logic [2*WIDTH-1:0] PRODUCT
);
  import mul_seq_pkg::*;

  logic [1:0]         state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mq;
  logic [CNT_W-1:0]   cnt;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic [2*WIDTH:0]   ext;
  logic [2*WIDTH-1:0] nxt;

  // Gating the multiplicand makes a zero multiplier bit a pass-through with carry 0.
  assign addend = mcand & {WIDTH{mq[0]}};

  FullAdder #(.W(WIDTH)) u_add (
    .A    (acc),
    .B    (addend),
    .CIN  (1'b0),
    .S    (sum),
    .COUT (carry)
  );

  // The carry becomes the top bit after the shift, so nothing is ever lost.
  assign ext = {carry, sum, mq};
  assign nxt = ext[2*WIDTH:1];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= ST_IDLE;
      mcand   <= '0;
      acc     <= '0;
      mq      <= '0;
      cnt     <= '0;
      PRODUCT <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            mcand <= A;
            mq    <= B;
            acc   <= '0;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          {acc, mq} <= nxt;
          if (cnt == LAST_ITER) begin
            PRODUCT <= nxt;
            state   <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign BUSY = (state == ST_RUN) || (state == ST_DONE);
  assign DONE = (state == ST_DONE);

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: driver queues expected products, monitor checks on DONE.
module tb_mul_sequencer;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        START = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        BUSY;
  logic        DONE;
  logic [31:0] PRODUCT;

  mul_sequencer #(.WIDTH(16)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .START   (START),
    .A       (A),
    .B       (B),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .PRODUCT (PRODUCT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] prod;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] held = '0;
  logic        prev_done = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    failures++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Monitor: latency is counted from the accepting edge to the DONE cycle.
  always @(negedge CLK) begin
    if (!RST_N) begin
      prev_done = 1'b0;
    end else begin
      if (DONE) begin
        check32("done_busy", BUSY, 32'd1);
        check32("done_pulse_width", prev_done, 32'd0);
        if (sb.size() == 0) begin
          fail_now("unexpected_done", "got DONE=1 expected no DONE");
        end else begin
          mon_e = sb.pop_front();
          check32("product", PRODUCT, mon_e.prod);
          check32("latency", cyc - mon_e.acc, 32'd16);
          held = mon_e.prod;
        end
      end else begin
        check32("product_hold", PRODUCT, held);
      end
      prev_done = DONE;
    end
  end

  task automatic wait_idle();
    int guard = 0;
    @(negedge CLK);
    while (BUSY && guard < 40) begin
      @(negedge CLK);
      guard++;
    end
    if (BUSY) fail_now("idle_timeout", "got BUSY=1 expected BUSY=0 within 40 cycles");
  endtask

  task automatic push_exp(input logic [31:0] p, input int acc);
    exp_t e;
    e.prod = p;
    e.acc  = acc;
    sb.push_back(e);
  endtask

  task automatic mul(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp);
    wait_idle();
    A = a;
    B = b;
    START = 1'b1;
    push_exp(exp, cyc + 1);
    @(posedge CLK);
    #1 START = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge CLK);
      guard++;
    end
    check32("scoreboard_drained", sb.size(), 32'd0);
  endtask

  logic [15:0] dir_a[8] = '{16'hFFFF, 16'h1234, 16'h0000, 16'hFFFF, 16'h0001, 16'h8000, 16'h8000, 16'h00FF};
  logic [15:0] dir_b[8] = '{16'hFFFF, 16'h0000, 16'hABCD, 16'h0001, 16'hFFFF, 16'h0002, 16'h8000, 16'h0100};
  logic [31:0] dir_p[8] = '{32'hFFFE0001, 32'h0, 32'h0, 32'h0000FFFF, 32'h0000FFFF,
                            32'h00010000, 32'h40000000, 32'h0000FF00};

  initial begin
    int bcount;
    int c0;
    logic [15:0] ra;
    logic [15:0] rb;

    #1;
    check32("reset_busy", BUSY, 32'd0);
    check32("reset_done", DONE, 32'd0);
    check32("reset_product", PRODUCT, 32'd0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;

    // 3*5 with BUSY duration measured
    mul(16'd3, 16'd5, 32'h0000000F);
    bcount = 0;
    @(negedge CLK);
    while (BUSY && bcount < 40) begin
      bcount++;
      @(negedge CLK);
    end
    check32("busy_cycles", bcount, 32'd17);

    for (int i = 0; i < 8; i++) mul(dir_a[i], dir_b[i], dir_p[i]);
    drain();

    // START held high, operands changed mid-run; second multiply must start right after DONE
    wait_idle();
    A = 16'd7;
    B = 16'd9;
    START = 1'b1;
    c0 = cyc + 1;
    push_exp(32'd63, c0);
    @(posedge CLK);
    #1;
    A = 16'd1;
    B = 16'd1;
    repeat (17) @(posedge CLK);
    push_exp(32'd1, c0 + 18);
    @(posedge CLK);
    #1 START = 1'b0;
    drain();

    // Reset after 8 iterations aborts the multiply
    mul(16'd100, 16'd200, 32'd20000);
    repeat (8) @(posedge CLK);
    #2;
    RST_N = 1'b0;
    sb.delete();
    held = '0;
    #1;
    check32("abort_busy", BUSY, 32'd0);
    check32("abort_done", DONE, 32'd0);
    check32("abort_product", PRODUCT, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (30) @(negedge CLK);
    mul(16'd100, 16'd200, 32'd20000);
    drain();

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      mul(ra, rb, {16'h0, ra} * {16'h0, rb});
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
